// File: rtl/frame_stack_pkg.sv
// Shared definitions for the frame stack: frame layout, position codes
// and FSM state encoding.
package frame_stack_pkg;

  localparam int unsigned POS_W   = 5;
  localparam int unsigned FIELD_W = 8;
  localparam int unsigned FRAME_W = POS_W + 4 * FIELD_W;  // 37

  // Field offsets inside a packed frame {position, i, z, k, l}
  localparam int unsigned OFF_L   = 0;
  localparam int unsigned OFF_K   = 8;
  localparam int unsigned OFF_Z   = 16;
  localparam int unsigned OFF_I   = 24;
  localparam int unsigned OFF_POS = 32;

  // Resume-position codes shared with the ex stage
  typedef enum logic [POS_W-1:0] {
    POS_NONE        = 5'd0,
    POS_A_INSERTION = 5'd1,
    POS_C_INSERTION = 5'd2,
    POS_G_INSERTION = 5'd3,
    POS_T_INSERTION = 5'd4,
    POS_A_DELETION  = 5'd5,
    POS_C_DELETION  = 5'd6,
    POS_G_DELETION  = 5'd7,
    POS_T_DELETION  = 5'd8
  } pos_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  function automatic logic [FRAME_W-1:0] pack_frame(
    input logic [POS_W-1:0]   pos,
    input logic [FIELD_W-1:0] i,
    input logic [FIELD_W-1:0] z,
    input logic [FIELD_W-1:0] k,
    input logic [FIELD_W-1:0] l
  );
    return {pos, i, z, k, l};
  endfunction

endpackage

// File: rtl/frame_stack_ram.sv
// DEPTH x FRAME_W register file: one full-frame write port, one
// position-only write port and a registered top-of-stack read port.
module frame_ram
  import frame_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [AW-1:0]      i_waddr,
  input  logic [FRAME_W-1:0] i_wdata,
  input  logic               i_pwe,
  input  logic [AW-1:0]      i_paddr,
  input  logic [POS_W-1:0]   i_pdata,
  input  logic               i_rd_en,
  input  logic [AW-1:0]      i_raddr,
  output logic [FRAME_W-1:0] o_rdata
);

  logic [FRAME_W-1:0] r_mem [DEPTH];
  logic [FRAME_W-1:0] r_rdata;

  // Storage writes; the two ports never target the same entry
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
    if (i_pwe)
      r_mem[i_paddr][OFF_POS +: POS_W] <= i_pdata;
  end

  // Registered read; a same-cycle full write is forwarded so a freshly
  // loaded root frame is visible one cycle after it is written
  always_ff @(posedge clk) begin
    if (rst)
      r_rdata <= '0;
    else if (i_rd_en)
      r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_stack.sv
// Recursion frame stack downstream of the ex stage.
// Optional hit capture is built when FRAME_STACK_HIT_EN is defined.
module frame_stack
  import frame_stack_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned PW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    i0,
  input  logic [7:0]    z0,
  input  logic [7:0]    k0,
  input  logic [7:0]    l0,
  input  logic          res_valid,
  input  logic          new_call,
  input  logic [7:0]    i_new,
  input  logic [7:0]    z_new,
  input  logic [7:0]    k_new,
  input  logic [7:0]    l_new,
  input  logic          en_new_position,
  input  logic [4:0]    new_position,
  input  logic          over_1,
  input  logic          over_2,
  input  logic          finish,
  input  logic [7:0]    current_k,
  input  logic [7:0]    current_l,
  output logic          frame_valid,
  output logic [4:0]    top_position,
  output logic [7:0]    top_i,
  output logic [7:0]    top_z,
  output logic [7:0]    top_k,
  output logic [7:0]    top_l,
  output logic [PW-1:0] depth,
  output logic          done,
  output logic          err,
  output logic          hit_valid,
  output logic [7:0]    hit_k,
  output logic [7:0]    hit_l,
  output logic [7:0]    hit_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        r_state;
  logic [PW-1:0] r_depth;
  logic          r_frame_valid;
  logic          r_done;
  logic          r_err;

  logic          w_start;
  logic          w_accept;
  logic          w_pop;
  logic          w_full;
  logic          w_push;
  logic          w_rewrite;
  logic [PW-1:0] w_depth_m1;
  logic [AW-1:0] w_top_idx;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [FRAME_W-1:0] w_wdata;
  logic          w_rd_en;
  logic [AW-1:0] w_raddr;
  logic [FRAME_W-1:0] w_rdata;

  assign w_depth_m1 = r_depth - PW'(1);
  assign w_top_idx  = w_depth_m1[AW-1:0];
  assign w_full     = (r_depth == PW'(DEPTH));
  assign w_pop      = over_2 | over_1 | finish;

  // Decode the accepted command into storage write/read strobes
  always_comb begin
    w_start   = start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                          (r_state == S_ERR));
    w_accept  = (r_state == S_ISSUE) && res_valid;
    w_push    = w_accept && !w_pop && new_call && !w_full;
    // With new_call the top rewrite rides along with the push; a refused
    // push leaves the whole stack untouched, rewrite included.
    w_rewrite = w_accept && !w_pop && (new_call ? !w_full : en_new_position);
    w_we      = w_start || w_push;
    w_waddr   = w_start ? '0 : r_depth[AW-1:0];
    w_wdata   = w_start ? pack_frame(POS_NONE, i0, z0, k0, l0)
                        : pack_frame(POS_NONE, i_new, z_new, k_new, l_new);
    w_rd_en   = w_start || (r_state == S_SETTLE);
    w_raddr   = w_start ? '0 : w_top_idx;
  end

  frame_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_frame_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_pwe   (w_rewrite),
    .i_paddr (w_top_idx),
    .i_pdata (new_position),
    .i_rd_en (w_rd_en),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

`ifdef FRAME_STACK_HIT_EN
  logic       r_hit_valid;
  logic [7:0] r_hit_k;
  logic [7:0] r_hit_l;
  logic [7:0] r_hit_count;
`else
  logic w_unused_hit;
  assign w_unused_hit = ^{current_k, current_l};
`endif

  // Control FSM: depth tracking, status flags and hit capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_depth       <= '0;
      r_frame_valid <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
`ifdef FRAME_STACK_HIT_EN
      r_hit_valid   <= 1'b0;
      r_hit_k       <= '0;
      r_hit_l       <= '0;
      r_hit_count   <= '0;
`endif
    end else begin
`ifdef FRAME_STACK_HIT_EN
      r_hit_valid <= 1'b0;
`endif
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_state       <= S_ISSUE;
            r_depth       <= PW'(1);
            r_frame_valid <= 1'b1;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
`ifdef FRAME_STACK_HIT_EN
            r_hit_count   <= '0;
`endif
          end
        end
        S_ISSUE: begin
          if (res_valid) begin
            r_frame_valid <= 1'b0;
            if (w_pop) begin
`ifdef FRAME_STACK_HIT_EN
              if (over_2) begin
                r_hit_valid <= 1'b1;
                r_hit_k     <= current_k;
                r_hit_l     <= current_l;
                if (r_hit_count != 8'hFF)
                  r_hit_count <= r_hit_count + 8'd1;
              end
`endif
              r_depth <= w_depth_m1;
              if (r_depth == PW'(1)) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_SETTLE;
              end
            end else if (new_call && w_full) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              if (new_call)
                r_depth <= r_depth + PW'(1);
              r_state <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          r_state       <= S_ISSUE;
          r_frame_valid <= 1'b1;
        end
        default: begin
          r_state       <= S_IDLE;
          r_frame_valid <= 1'b0;
        end
      endcase
    end
  end

  assign frame_valid  = r_frame_valid;
  assign depth        = r_depth;
  assign done         = r_done;
  assign err          = r_err;
  assign top_position = w_rdata[OFF_POS +: POS_W];
  assign top_i        = w_rdata[OFF_I +: FIELD_W];
  assign top_z        = w_rdata[OFF_Z +: FIELD_W];
  assign top_k        = w_rdata[OFF_K +: FIELD_W];
  assign top_l        = w_rdata[OFF_L +: FIELD_W];

`ifdef FRAME_STACK_HIT_EN
  assign hit_valid = r_hit_valid;
  assign hit_k     = r_hit_k;
  assign hit_l     = r_hit_l;
  assign hit_count = r_hit_count;
`else
  assign hit_valid = 1'b0;
  assign hit_k     = '0;
  assign hit_l     = '0;
  assign hit_count = '0;
`endif

endmodule

// File: tb/tb_frame_stack.sv
// Directed self-checking bench for frame_stack (DEPTH=4).
module tb_frame_stack;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = $clog2(DEPTH + 1);
`ifdef FRAME_STACK_HIT_EN
  localparam bit HIT = 1'b1;
`else
  localparam bit HIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, res_valid, new_call, en_new_position;
  logic          over_1, over_2, finish;
  logic [7:0]    i0, z0, k0, l0, i_new, z_new, k_new, l_new;
  logic [7:0]    current_k, current_l;
  logic [4:0]    new_position;
  logic          frame_valid, done, err, hit_valid;
  logic [4:0]    top_position;
  logic [7:0]    top_i, top_z, top_k, top_l, hit_k, hit_l, hit_count;
  logic [PW-1:0] depth;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frame_stack #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .i0(i0), .z0(z0), .k0(k0), .l0(l0),
    .res_valid(res_valid), .new_call(new_call),
    .i_new(i_new), .z_new(z_new), .k_new(k_new), .l_new(l_new),
    .en_new_position(en_new_position), .new_position(new_position),
    .over_1(over_1), .over_2(over_2), .finish(finish),
    .current_k(current_k), .current_l(current_l),
    .frame_valid(frame_valid), .top_position(top_position),
    .top_i(top_i), .top_z(top_z), .top_k(top_k), .top_l(top_l),
    .depth(depth), .done(done), .err(err),
    .hit_valid(hit_valid), .hit_k(hit_k), .hit_l(hit_l), .hit_count(hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle 1ns so outputs of that edge are visible
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; res_valid = 0; new_call = 0; en_new_position = 0;
    over_1 = 0; over_2 = 0; finish = 0;
  endtask

  task automatic do_start(input logic [7:0] i, input logic [7:0] z,
                          input logic [7:0] k, input logic [7:0] l);
    start = 1; i0 = i; z0 = z; k0 = k; l0 = l;
    tick();
    idle_inputs();
  endtask

  task automatic do_result(input logic ov2, input logic ov1, input logic fin,
                           input logic nc, input logic enp, input logic [4:0] pos,
                           input logic [7:0] inew);
    res_valid = 1; over_2 = ov2; over_1 = ov1; finish = fin;
    new_call = nc; en_new_position = enp; new_position = pos;
    i_new = inew; z_new = 8'd0; k_new = inew + 8'd1; l_new = inew + 8'd2;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1; i0 = 0; z0 = 0; k0 = 0; l0 = 0;
    i_new = 0; z_new = 0; k_new = 0; l_new = 0; new_position = 0;
    current_k = 0; current_l = 0;
    tick(); tick();
    rst = 0;
    chk("rst_fv", frame_valid, 0);
    chk("rst_depth", depth, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_top_i", top_i, 0);
    chk("rst_hitcnt", hit_count, 0);

    // Root frame
    do_start(8'd3, 8'd1, 8'd0, 8'd20);
    chk("root_fv", frame_valid, 1);
    chk("root_pos", top_position, 0);
    chk("root_i", top_i, 3);
    chk("root_z", top_z, 1);
    chk("root_l", top_l, 20);
    chk("root_depth", depth, 1);

    // Push with position rewrite A_INSERTION (1)
    do_result(0, 0, 0, 1, 0, 5'd1, 8'd2);
    chk("push_settle_fv", frame_valid, 0);
    chk("push_depth", depth, 2);
    tick();
    chk("push_fv", frame_valid, 1);
    chk("push_i", top_i, 2);
    chk("push_k", top_k, 3);
    chk("push_pos", top_position, 0);

    // start ignored in ISSUE
    do_start(8'd99, 8'd99, 8'd99, 8'd99);
    chk("start_ign_depth", depth, 2);
    chk("start_ign_i", top_i, 2);
    chk("start_ign_fv", frame_valid, 1);

    // Pop reveals rewritten parent
    do_result(0, 1, 0, 0, 0, 5'd0, 8'd0);
    chk("pop_depth", depth, 1);
    chk("pop_settle_fv", frame_valid, 0);
    tick();
    chk("pop_pos", top_position, 1);
    chk("pop_i", top_i, 3);

    // Push with G_DELETION (7), then over_2 hit
    do_result(0, 0, 0, 1, 0, 5'd7, 8'd1);
    tick();
    chk("push2_i", top_i, 1);
    current_k = 8'd5; current_l = 8'd7;
    do_result(1, 0, 0, 0, 0, 5'd0, 8'd0);
    chk("hit_valid", hit_valid, HIT ? 1 : 0);
    chk("hit_k", hit_k, HIT ? 5 : 0);
    chk("hit_l", hit_l, HIT ? 7 : 0);
    chk("hit_count", hit_count, HIT ? 1 : 0);
    chk("hit_depth", depth, 1);
    tick();
    chk("hit_pulse_end", hit_valid, 0);
    chk("hit_fv", frame_valid, 1);
    chk("hit_top_pos", top_position, 7);

    // over_1 together with new_call: pop only
    do_result(0, 0, 0, 1, 0, 5'd2, 8'd6);
    tick();
    chk("push3_depth", depth, 2);
    do_result(0, 1, 0, 1, 0, 5'd4, 8'd9);
    chk("ov1nc_depth", depth, 1);
    tick();
    chk("ov1nc_i", top_i, 3);
    chk("ov1nc_pos", top_position, 2);

    // Final pop -> DONE
    do_result(0, 0, 1, 0, 0, 5'd0, 8'd0);
    chk("done_rise", done, 1);
    chk("done_fv", frame_valid, 0);
    chk("done_depth", depth, 0);
    do_result(0, 0, 0, 1, 0, 5'd0, 8'd8);
    chk("done_ign_depth", depth, 0);
    chk("done_hold", done, 1);
    chk("done_fv2", frame_valid, 0);

    // Restart clears done and hit_count
    do_start(8'd10, 8'd2, 8'd3, 8'd4);
    chk("restart_done", done, 0);
    chk("restart_fv", frame_valid, 1);
    chk("restart_i", top_i, 10);
    chk("restart_hitcnt", hit_count, 0);

    // Position rewrite alone (G_INSERTION 3)
    do_result(0, 0, 0, 0, 1, 5'd3, 8'd0);
    tick();
    chk("rewrite_pos", top_position, 3);
    chk("rewrite_depth", depth, 1);
    chk("rewrite_i", top_i, 10);

    // No flag set: no change
    do_result(0, 0, 0, 0, 0, 5'd6, 8'd0);
    chk("noop_settle_fv", frame_valid, 0);
    tick();
    chk("noop_pos", top_position, 3);
    chk("noop_depth", depth, 1);

    // Fill the stack, then overflow
    for (int n = 1; n <= 3; n++) begin
      do_result(0, 0, 0, 1, 0, 5'd1, 8'(20 + n));
      tick();
    end
    chk("full_depth", depth, 4);
    chk("full_i", top_i, 23);
    do_result(0, 0, 0, 1, 0, 5'd1, 8'd30);
    chk("ovf_err", err, 1);
    chk("ovf_depth", depth, 4);
    chk("ovf_fv", frame_valid, 0);
    tick();
    chk("ovf_err_hold", err, 1);
    chk("ovf_fv_hold", frame_valid, 0);

    // Start from ERR
    do_start(8'd50, 8'd0, 8'd0, 8'd0);
    chk("errstart_err", err, 0);
    chk("errstart_fv", frame_valid, 1);
    chk("errstart_i", top_i, 50);
    chk("errstart_depth", depth, 1);

    // Reset during SETTLE
    do_result(0, 0, 0, 1, 0, 5'd1, 8'd40);
    chk("pre_rst_fv", frame_valid, 0);
    rst = 1;
    tick();
    rst = 0;
    chk("rstmid_fv", frame_valid, 0);
    chk("rstmid_depth", depth, 0);
    chk("rstmid_i", top_i, 0);
    chk("rstmid_pos", top_position, 0);
    chk("rstmid_err", err, 0);
    chk("rstmid_done", done, 0);
    tick();
    chk("rstmid_idle_fv", frame_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
